// File: rtl/ex_issue_buf.sv
// ============================================================================
// ex_issue_buf
// ----------------------------------------------------------------------------
// Two-entry in-order issue buffer between instruction decode and the execute
// stage of the 16-bit pipeline.
//
// Decode pushes a decoded instruction under in_valid/in_ready:
//   - opcode and function field
//   - the five ALU control signals
//   - both operands
// Execute drains the head entry under out_valid/out_ready. The buffer is a
// circular store with 1-bit head/tail pointers and a 2-bit count.
//
// A HALT (opcode 5'b00000) is stored and issued like any other instruction,
// but it closes the input on the edge it is accepted. The input stays closed
// until flush or rst.
//
// Optional feature (macro EX_ISSUE_BUF_FLOW_EN):
//   When the macro is defined and the buffer is empty, an incoming
//   instruction is forwarded combinationally to the outputs (zero-latency
//   bypass). It is stored only if execute does not take it that cycle.
//   When the macro is undefined there is no combinational in->out path.
//
// Parameters:
//   N              operand width (default 16)
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            synchronous active-high reset (clears entries as well)
//   flush          discard all buffered entries, clear halted
//
//   in_valid       decode presents an instruction
//   in_ready       buffer can accept this cycle
//   in_opCode      instruction fields to capture
//   in_funct
//   in_aluOp
//   in_invA
//   in_invB
//   in_Cin
//   in_sign
//   in_A
//   in_B
//
//   out_valid      head entry valid for execute
//   out_ready      execute consumes the head this cycle
//   out_*          head entry fields; all zero while out_valid=0
//
//   occupancy      registered entry count (0..2)
//   halted         HALT accepted; input closed
// ============================================================================
module ex_issue_buf #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_opCode,
    input  logic [1:0]   in_funct,
    input  logic [2:0]   in_aluOp,
    input  logic         in_invA,
    input  logic         in_invB,
    input  logic         in_Cin,
    input  logic         in_sign,
    input  logic [N-1:0] in_A,
    input  logic [N-1:0] in_B,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   out_opCode,
    output logic [1:0]   out_funct,
    output logic [2:0]   out_aluOp,
    output logic         out_invA,
    output logic         out_invB,
    output logic         out_Cin,
    output logic         out_sign,
    output logic [N-1:0] out_A,
    output logic [N-1:0] out_B,

    output logic [1:0]   occupancy,
    output logic         halted
);

    // Packed entry layout, MSB first:
    //   opCode, funct, aluOp, invA, invB, Cin, sign, A, B
    localparam int EW = 5 + 2 + 3 + 4 + 2 * N;

    logic          head_reg;
    logic          tail_reg;
    logic [1:0]    count_reg;
    logic          halted_reg;

    logic          push;        // handshake accepted on the input side
    logic          store_push;  // accepted instruction is written into the store
    logic          pop_store;   // head of the store is consumed
    logic [EW-1:0] in_word;
    logic [EW-1:0] head_word;
    logic [EW-1:0] out_word;
    logic [EW-1:0] out_data;
    logic [EW-1:0] entry_q [2];

    assign in_word = {in_opCode, in_funct, in_aluOp,
                      in_invA, in_invB, in_Cin, in_sign,
                      in_A, in_B};

    // in_ready depends only on state and rst, never on out_ready.
    assign in_ready = !rst && (count_reg != 2'd2) && !halted_reg;
    assign push     = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Entry storage: one register per slot, written at the tail pointer.
    // Writes are suppressed during flush so a discarded push leaves no trace.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (store_push && !flush && (tail_reg == 1'(gi))) begin
                    entry_reg <= in_word;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign head_word = entry_q[head_reg];

`ifdef EX_ISSUE_BUF_FLOW_EN
    // ------------------------------------------------------------------------
    // Zero-latency bypass through an empty buffer.
    //
    // The bypass implies in_ready: count is 0, halted is 0 and rst is low.
    // If execute takes the instruction this cycle it is never written.
    // Otherwise it is stored as a normal push.
    //
    // Flush suppresses the bypass. The push in that cycle is then discarded
    // by the flush priority in the control block.
    // ------------------------------------------------------------------------
    logic bypass;

    assign bypass     = (count_reg == 2'd0) && in_valid && !halted_reg
                        && !rst && !flush;
    assign out_valid  = (count_reg != 2'd0) || bypass;
    assign pop_store  = (count_reg != 2'd0) && out_ready;
    assign store_push = push && !(bypass && out_ready);
    assign out_word   = bypass ? in_word : head_word;
`else
    assign out_valid  = (count_reg != 2'd0);
    assign pop_store  = out_valid && out_ready;
    assign store_push = push;
    assign out_word   = head_word;
`endif

    // Data outputs are forced to zero whenever nothing is being presented.
    assign out_data = out_valid ? out_word : '0;
    assign {out_opCode, out_funct, out_aluOp,
            out_invA, out_invB, out_Cin, out_sign,
            out_A, out_B} = out_data;

    // ------------------------------------------------------------------------
    // Pointer, count and halt control.
    //
    // Flush (and rst) override any push/pop in the same cycle. A pop in that
    // cycle is treated as consumed with no further effect.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg   <= 1'b0;
            tail_reg   <= 1'b0;
            count_reg  <= 2'd0;
            halted_reg <= 1'b0;
        end else begin
            if (store_push) begin
                tail_reg <= ~tail_reg;
            end
            if (pop_store) begin
                head_reg <= ~head_reg;
            end
            count_reg <= count_reg + 2'(store_push) - 2'(pop_store);
            // A HALT closes the input even when it is bypassed straight to
            // execute without being stored.
            if (push && (in_opCode == 5'b00000)) begin
                halted_reg <= 1'b1;
            end
        end
    end

    assign occupancy = count_reg;
    assign halted    = halted_reg;

endmodule
